// File: rtl/afc_cal_engine.sv
// rtl/afc_cal_engine.sv - automatic frequency calibration: binary search, verify and tracking of an oscillator code
module afc_cal_engine #(
  parameter int CODE_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 16,
  parameter int TOL           = 2,
  parameter int RELOCK_THR    = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   afctrigger,
  input  logic                   track_en,
  input  logic [COUNT_WIDTH-1:0] target_count,
  output logic                   meas_start,
  input  logic                   meas_valid,
  input  logic [COUNT_WIDTH-1:0] meas_count,
  output logic [CODE_WIDTH-1:0]  control_code_out,
  output logic                   afc_status,
  output logic                   afc_busy,
  output logic                   afc_error
);

  localparam int CNT_W = $clog2((TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES) + 1;
  localparam int BIT_W = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;
  localparam int DW    = COUNT_WIDTH + 1;

  localparam logic [CODE_WIDTH-1:0] CODE_MID = CODE_WIDTH'(1) << (CODE_WIDTH - 1);
  localparam logic [CODE_WIDTH-1:0] CODE_MAX = '1;
  localparam logic [CODE_WIDTH-1:0] CODE_MIN = '0;
  localparam logic [BIT_W-1:0]      BIT_TOP  = BIT_W'(CODE_WIDTH - 1);
  localparam logic [CNT_W-1:0]      SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic signed [DW-1:0] TOL_P = DW'(TOL);
  localparam logic signed [DW-1:0] TOL_N = -DW'(TOL);
  localparam logic signed [DW-1:0] THR_P = DW'(RELOCK_THR);
  localparam logic signed [DW-1:0] THR_N = -DW'(RELOCK_THR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_MEAS   = 3'd2,
    S_UPDATE = 3'd3,
    S_VERIFY = 3'd4,
    S_LOCKED = 3'd5,
    S_TRACK  = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Which decision state consumes the result of the current SETTLE/MEAS round.
  typedef enum logic [1:0] {
    M_SEARCH = 2'd0,
    M_VERIFY = 2'd1,
    M_TRACK  = 2'd2
  } mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  logic [CODE_WIDTH-1:0]  code_q, code_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [DW-1:0]   diff_q, diff_d;
  logic                   pend_q, pend_d;
  logic                   status_q, status_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;
  logic                   mstart_q, mstart_d;
  logic                   trig_q;

  logic                   trig_rise;
  logic signed [DW-1:0]   diff_now;
  logic                   in_tol;
  logic                   relock;
  logic                   diff_pos;
  logic                   diff_neg;
  logic                   restart;

  // Extended by one bit so the subtraction can never wrap.
  assign diff_now  = $signed({1'b0, meas_count}) - $signed({1'b0, target_count});
  assign trig_rise = afctrigger & ~trig_q;
  assign in_tol    = (diff_q >= TOL_N) && (diff_q <= TOL_P);
  assign relock    = (diff_q > THR_P) || (diff_q < THR_N);
  assign diff_neg  = diff_q[DW-1];
  assign diff_pos  = ~diff_q[DW-1] & (|diff_q);

  // Next-state and datapath decisions; every register holds unless a branch changes it.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    code_d   = code_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    pend_d   = pend_q;
    status_d = status_q;
    busy_d   = busy_q;
    error_d  = error_q;
    mstart_d = 1'b0;
    restart  = trig_rise;

    if (!trig_rise) begin
      case (state_q)
        S_IDLE: begin
        end

        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d    = '0;
            mstart_d = 1'b1;
            state_d  = S_MEAS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_MEAS: begin
          // A strobe coincident with meas_start cannot belong to this window.
          if (meas_valid && !mstart_q) begin
            diff_d = diff_now;
            pend_d = 1'b1;
            cnt_d  = '0;
            case (mode_q)
              M_SEARCH: state_d = S_UPDATE;
              M_VERIFY: state_d = S_VERIFY;
              default:  state_d = S_TRACK;
            endcase
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d    = '0;
            state_d  = S_ERROR;
            error_d  = 1'b1;
            busy_d   = 1'b0;
            status_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_UPDATE: begin
          pend_d = 1'b0;
          if (in_tol) begin
            state_d  = S_LOCKED;
            status_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            // Counted too many edges: the trial bit made the oscillator too fast.
            if (diff_pos) begin
              code_d[bit_q] = 1'b0;
            end
            if (bit_q != '0) begin
              bit_d         = bit_q - BIT_W'(1);
              code_d[bit_d] = 1'b1;
              cnt_d         = '0;
              state_d       = S_SETTLE;
            end else begin
              state_d = S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          if (pend_q) begin
            pend_d = 1'b0;
            if (in_tol) begin
              state_d  = S_LOCKED;
              status_d = 1'b1;
              busy_d   = 1'b0;
            end else if (track_en) begin
              state_d = S_TRACK;
              busy_d  = 1'b0;
            end else begin
              state_d  = S_ERROR;
              error_d  = 1'b1;
              busy_d   = 1'b0;
              status_d = 1'b0;
            end
          end else begin
            mode_d  = M_VERIFY;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end

        S_LOCKED: begin
          status_d = 1'b1;
          busy_d   = 1'b0;
          if (track_en) begin
            pend_d  = 1'b0;
            state_d = S_TRACK;
          end
        end

        S_TRACK: begin
          if (pend_q) begin
            pend_d = 1'b0;
            if (relock) begin
              restart = 1'b1;
            end else if (in_tol) begin
              status_d = 1'b1;
              state_d  = track_en ? S_SETTLE : S_LOCKED;
            end else if (diff_neg && code_q == CODE_MAX) begin
              state_d  = S_ERROR;
              error_d  = 1'b1;
              status_d = 1'b0;
            end else if (diff_pos && code_q == CODE_MIN) begin
              state_d  = S_ERROR;
              error_d  = 1'b1;
              status_d = 1'b0;
            end else begin
              code_d  = diff_neg ? code_q + CODE_WIDTH'(1) : code_q - CODE_WIDTH'(1);
              state_d = track_en ? S_SETTLE : S_LOCKED;
            end
            cnt_d = '0;
          end else if (track_en) begin
            mode_d  = M_TRACK;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else begin
            state_d  = S_LOCKED;
            status_d = 1'b1;
          end
        end

        S_ERROR: begin
          error_d = 1'b1;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Fresh binary search from mid-scale, abandoning whatever was in flight.
    if (restart) begin
      state_d  = S_SETTLE;
      mode_d   = M_SEARCH;
      code_d   = CODE_MID;
      bit_d    = BIT_TOP;
      cnt_d    = '0;
      pend_d   = 1'b0;
      status_d = 1'b0;
      error_d  = 1'b0;
      busy_d   = 1'b1;
      mstart_d = 1'b0;
    end
  end

  // State and datapath registers; the trigger history resets high so a level held through reset is not an edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= M_SEARCH;
      code_q   <= CODE_MID;
      bit_q    <= BIT_TOP;
      cnt_q    <= '0;
      diff_q   <= '0;
      pend_q   <= 1'b0;
      status_q <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      mstart_q <= 1'b0;
      trig_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      pend_q   <= pend_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
      mstart_q <= mstart_d;
      trig_q   <= afctrigger;
    end
  end

  assign meas_start       = mstart_q;
  assign control_code_out = code_q;
  assign afc_status       = status_q;
  assign afc_busy         = busy_q;
  assign afc_error        = error_q;

endmodule

// File: tb/tb_afc_cal_engine.sv
// tb/tb_afc_cal_engine.sv - directed self-checking bench for afc_cal_engine with a window-counter model
module tb_afc_cal_engine;

  logic        refclk;
  logic        rst_n;
  logic        afctrigger;
  logic        track_en;
  logic [15:0] target_count;
  logic        meas_start;
  logic        meas_valid;
  logic [15:0] meas_count;
  logic [7:0]  control_code_out;
  logic        afc_status;
  logic        afc_busy;
  logic        afc_error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Counter model state: written only by the model process, except the two knobs.
  int          nmeas = 0;
  int          pend_cnt = 0;
  logic [15:0] resp = '0;
  logic [7:0]  trial [0:255];
  logic        model_on;
  logic [15:0] model_off;

  afc_cal_engine #(
    .CODE_WIDTH(8), .COUNT_WIDTH(16), .TOL(2), .RELOCK_THR(64),
    .SETTLE_CYCLES(16), .TIMEOUT(4096)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .afctrigger(afctrigger), .track_en(track_en),
    .target_count(target_count), .meas_start(meas_start), .meas_valid(meas_valid),
    .meas_count(meas_count), .control_code_out(control_code_out),
    .afc_status(afc_status), .afc_busy(afc_busy), .afc_error(afc_error)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Window counter: answers 8*code - offset, 20 cycles after meas_start.
  initial begin
    meas_valid = 1'b0;
    meas_count = '0;
    forever begin
      @(negedge refclk);
      meas_valid = 1'b0;
      if (!rst_n) begin
        pend_cnt = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt = pend_cnt - 1;
          if (pend_cnt == 0) begin
            meas_valid = 1'b1;
            meas_count = resp;
          end
        end
        if (meas_start) begin
          trial[nmeas[7:0]] = control_code_out;
          nmeas = nmeas + 1;
          if (model_on) begin
            pend_cnt = 20;
            resp = ({8'd0, control_code_out} << 3) - model_off;
          end
        end
      end
    end
  end

  task automatic pulse_trigger;
    @(negedge refclk);
    afctrigger = 1'b1;
    @(negedge refclk);
    afctrigger = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge refclk);
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL reset_code: got %0d expected 128", control_code_out); end
    tests_run++; if (afc_status !== 1'b0) begin tests_failed++; $display("FAIL reset_status: got %b expected 0", afc_status); end
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", afc_busy); end
    tests_run++; if (afc_error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", afc_error); end
    tests_run++; if (meas_start !== 1'b0) begin tests_failed++; $display("FAIL reset_meas_start: got %b expected 0", meas_start); end
    rst_n = 1'b1;
    repeat (40) @(negedge refclk);
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL held_trigger_busy: got %b expected 0", afc_busy); end
    tests_run++; if (nmeas !== 0) begin tests_failed++; $display("FAIL held_trigger_meas: got %0d expected 0", nmeas); end
    afctrigger = 1'b0;
    @(negedge refclk);
  endtask

  task automatic test_search_1000;
    int base;
    int idx;
    logic [7:0] exp_codes [8];
    exp_codes = '{8'd128, 8'd64, 8'd96, 8'd112, 8'd120, 8'd124, 8'd126, 8'd125};
    track_en = 1'b0;
    target_count = 16'd1000;
    base = nmeas;
    pulse_trigger;
    tests_run++; if (afc_busy !== 1'b1) begin tests_failed++; $display("FAIL s1000_busy: got %b expected 1", afc_busy); end
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL s1000_start_code: got %0d expected 128", control_code_out); end
    for (int i = 0; i < 2000 && afc_busy; i++) @(negedge refclk);
    tests_run++; if (afc_status !== 1'b1) begin tests_failed++; $display("FAIL s1000_status: got %b expected 1", afc_status); end
    tests_run++; if (control_code_out !== 8'd125) begin tests_failed++; $display("FAIL s1000_code: got %0d expected 125", control_code_out); end
    tests_run++; if (nmeas - base !== 8) begin tests_failed++; $display("FAIL s1000_nmeas: got %0d expected 8", nmeas - base); end
    for (int i = 0; i < 8; i++) begin
      idx = base + i;
      tests_run++;
      if (trial[idx[7:0]] !== exp_codes[i]) begin
        tests_failed++;
        $display("FAIL s1000_trial%0d: got %0d expected %0d", i, trial[idx[7:0]], exp_codes[i]);
      end
    end
  endtask

  task automatic test_search_1024;
    int base;
    target_count = 16'd1024;
    base = nmeas;
    pulse_trigger;
    for (int i = 0; i < 2000 && afc_busy; i++) @(negedge refclk);
    tests_run++; if (afc_status !== 1'b1) begin tests_failed++; $display("FAIL s1024_status: got %b expected 1", afc_status); end
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL s1024_code: got %0d expected 128", control_code_out); end
    tests_run++; if (nmeas - base !== 1) begin tests_failed++; $display("FAIL s1024_nmeas: got %0d expected 1", nmeas - base); end
  endtask

  task automatic test_track;
    int base;
    bit saw126;
    bit dropped;
    bit busy_seen;
    target_count = 16'd1000;
    track_en = 1'b1;
    model_off = 16'd0;
    pulse_trigger;
    for (int i = 0; i < 2000 && afc_busy; i++) @(negedge refclk);
    tests_run++; if (afc_status !== 1'b1) begin tests_failed++; $display("FAIL trk_lock_status: got %b expected 1", afc_status); end
    tests_run++; if (control_code_out !== 8'd125) begin tests_failed++; $display("FAIL trk_lock_code: got %0d expected 125", control_code_out); end
    model_off = 16'd16;
    saw126 = 1'b0; dropped = 1'b0; busy_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge refclk);
      if (control_code_out == 8'd126) saw126 = 1'b1;
      if (!afc_status) dropped = 1'b1;
      if (afc_busy) busy_seen = 1'b1;
    end
    tests_run++; if (saw126 !== 1'b1) begin tests_failed++; $display("FAIL trk_saw126: got %b expected 1", saw126); end
    tests_run++; if (control_code_out !== 8'd127) begin tests_failed++; $display("FAIL trk_code: got %0d expected 127", control_code_out); end
    tests_run++; if (dropped !== 1'b0) begin tests_failed++; $display("FAIL trk_status_drop: got %b expected 0", dropped); end
    tests_run++; if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL trk_busy: got %b expected 0", busy_seen); end
    track_en = 1'b0;
    repeat (100) @(negedge refclk);
    base = nmeas;
    repeat (150) @(negedge refclk);
    tests_run++; if (nmeas - base !== 0) begin tests_failed++; $display("FAIL trk_off_meas: got %0d expected 0", nmeas - base); end
    tests_run++; if (afc_status !== 1'b1) begin tests_failed++; $display("FAIL trk_off_status: got %b expected 1", afc_status); end
    tests_run++; if (control_code_out !== 8'd127) begin tests_failed++; $display("FAIL trk_off_code: got %0d expected 127", control_code_out); end
    model_off = 16'd0;
  endtask

  task automatic test_verify_fail;
    int base;
    track_en = 1'b0;
    target_count = 16'd5000;
    base = nmeas;
    pulse_trigger;
    for (int i = 0; i < 3000 && !afc_error; i++) @(negedge refclk);
    tests_run++; if (afc_error !== 1'b1) begin tests_failed++; $display("FAIL vf_error: got %b expected 1", afc_error); end
    tests_run++; if (control_code_out !== 8'd255) begin tests_failed++; $display("FAIL vf_code: got %0d expected 255", control_code_out); end
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL vf_busy: got %b expected 0", afc_busy); end
    tests_run++; if (afc_status !== 1'b0) begin tests_failed++; $display("FAIL vf_status: got %b expected 0", afc_status); end
    tests_run++; if (nmeas - base !== 9) begin tests_failed++; $display("FAIL vf_nmeas: got %0d expected 9", nmeas - base); end
    target_count = 16'd1024;
    pulse_trigger;
    tests_run++; if (afc_error !== 1'b0) begin tests_failed++; $display("FAIL vf_clear_error: got %b expected 0", afc_error); end
    tests_run++; if (afc_busy !== 1'b1) begin tests_failed++; $display("FAIL vf_clear_busy: got %b expected 1", afc_busy); end
    for (int i = 0; i < 2000 && afc_busy; i++) @(negedge refclk);
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL vf_relock_code: got %0d expected 128", control_code_out); end
  endtask

  task automatic test_timeout;
    int cycles;
    model_on = 1'b0;
    pulse_trigger;
    for (int i = 0; i < 100 && !meas_start; i++) @(negedge refclk);
    tests_run++; if (meas_start !== 1'b1) begin tests_failed++; $display("FAIL to_meas_start: got %b expected 1", meas_start); end
    cycles = 0;
    for (int i = 0; i < 5000 && !afc_error; i++) begin
      @(negedge refclk);
      cycles++;
    end
    tests_run++; if (cycles !== 4096) begin tests_failed++; $display("FAIL to_cycles: got %0d expected 4096", cycles); end
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b expected 0", afc_busy); end
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL to_code: got %0d expected 128", control_code_out); end
    model_on = 1'b1;
  endtask

  task automatic test_retrigger;
    int base;
    target_count = 16'd1000;
    pulse_trigger;
    for (int i = 0; i < 500 && control_code_out != 8'd96; i++) @(negedge refclk);
    tests_run++; if (control_code_out !== 8'd96) begin tests_failed++; $display("FAIL rt_reach96: got %0d expected 96", control_code_out); end
    afctrigger = 1'b1;
    base = nmeas;
    @(negedge refclk);
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL rt_code: got %0d expected 128", control_code_out); end
    tests_run++; if (afc_busy !== 1'b1) begin tests_failed++; $display("FAIL rt_busy: got %b expected 1", afc_busy); end
    afctrigger = 1'b0;
    for (int i = 0; i < 2000 && afc_busy; i++) @(negedge refclk);
    tests_run++; if (control_code_out !== 8'd125) begin tests_failed++; $display("FAIL rt_lock_code: got %0d expected 125", control_code_out); end
    tests_run++; if (nmeas - base !== 8) begin tests_failed++; $display("FAIL rt_nmeas: got %0d expected 8", nmeas - base); end
  endtask

  task automatic test_async_reset;
    int base;
    target_count = 16'd1000;
    pulse_trigger;
    repeat (60) @(negedge refclk);
    tests_run++; if (afc_busy !== 1'b1) begin tests_failed++; $display("FAIL ar_pre_busy: got %b expected 1", afc_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (control_code_out !== 8'd128) begin tests_failed++; $display("FAIL ar_code: got %0d expected 128", control_code_out); end
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL ar_busy: got %b expected 0", afc_busy); end
    tests_run++; if (afc_status !== 1'b0) begin tests_failed++; $display("FAIL ar_status: got %b expected 0", afc_status); end
    tests_run++; if (afc_error !== 1'b0) begin tests_failed++; $display("FAIL ar_error: got %b expected 0", afc_error); end
    tests_run++; if (meas_start !== 1'b0) begin tests_failed++; $display("FAIL ar_meas_start: got %b expected 0", meas_start); end
    repeat (3) @(negedge refclk);
    rst_n = 1'b1;
    base = nmeas;
    repeat (60) @(negedge refclk);
    tests_run++; if (nmeas - base !== 0) begin tests_failed++; $display("FAIL ar_post_meas: got %0d expected 0", nmeas - base); end
    tests_run++; if (afc_busy !== 1'b0) begin tests_failed++; $display("FAIL ar_post_busy: got %b expected 0", afc_busy); end
  endtask

  initial begin
    rst_n        = 1'b0;
    afctrigger   = 1'b1;
    track_en     = 1'b0;
    target_count = 16'd1000;
    model_on     = 1'b1;
    model_off    = 16'd0;
    test_reset;
    test_search_1000;
    test_search_1024;
    test_track;
    test_verify_fail;
    test_timeout;
    test_retrigger;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/afc_cal_engine.md
AFC_CAL_ENGINE -- requirements
Module: afc_cal_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- CODE_WIDTH, 8, control-code width.
- COUNT_WIDTH, 16, measurement-count width.
- TOL, 2, lock tolerance in counts.
- RELOCK_THR, 64, tracking error that forces a full re-search.
- SETTLE_CYCLES, 16, refclk cycles waited after every code change.
- TIMEOUT, 4096, max refclk cycles from meas_start to meas_valid.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- refclk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- afctrigger  in  1  rising edge starts or restarts calibration.
- track_en  in  1  enables post-lock tracking.
- target_count  in  COUNT_WIDTH  desired divclk count per window.
- meas_start  out  1  one-cycle request to the external window counter.
- meas_valid  in  1  one-cycle strobe: meas_count is valid.
- meas_count  in  COUNT_WIDTH  divclk edges counted in the window.
- control_code_out  out  CODE_WIDTH  oscillator code; a higher code gives a higher frequency.
- afc_status  out  1  locked.
- afc_busy  out  1  search or verify in progress.
- afc_error  out  1  timeout or no convergence.

REQ-003 All logic SHALL be clocked on refclk rising edge, with rst_n asserted asynchronously and released synchronously.

Function
REQ-004 States SHALL be IDLE, SETTLE, MEAS, UPDATE, VERIFY, LOCKED, TRACK, ERROR.

REQ-005 afctrigger SHALL be edge-detected through one register; a rising edge in any state SHALL:
- set code to 2^(CODE_WIDTH-1);
- set bit index to CODE_WIDTH-1;
- clear afc_status and afc_error;
- set afc_busy;
- enter SETTLE.

REQ-006 SETTLE SHALL count SETTLE_CYCLES cycles, then pulse meas_start for exactly one cycle and enter MEAS.

REQ-007 MEAS SHALL accept meas_valid only from the cycle after meas_start; meas_valid in any other state or cycle SHALL be ignored.

REQ-008 MEAS SHALL enter ERROR if TIMEOUT cycles elapse without meas_valid, setting afc_error=1 and afc_busy=0, and holding the code.

REQ-009 diff SHALL be the signed (COUNT_WIDTH+1)-bit value meas_count - target_count, with no overflow.

REQ-010 UPDATE (search) SHALL behave as follows:
- if |diff|<=TOL: go LOCKED immediately (early lock);
- else if diff>0: clear the current trial bit;
- else keep it;
- then, if bit index>0: decrement it, set the new trial bit, and go SETTLE;
- else go VERIFY.

REQ-011 VERIFY SHALL run one SETTLE/MEAS cycle on the final code:
- |diff|<=TOL goes to LOCKED;
- otherwise TRACK if track_en=1, else ERROR.

REQ-012 LOCKED SHALL set afc_status=1 and afc_busy=0; with track_en=1 it SHALL go to TRACK, otherwise it SHALL hold until the next trigger.

REQ-013 TRACK SHALL repeat SETTLE/MEAS with afc_busy=0 and, per measurement:
- |diff|<=TOL: code unchanged, afc_status=1;
- diff<-TOL: code+1;
- diff>TOL: code-1;
- |diff|>RELOCK_THR: afc_status=0 and a full search restarts as in REQ-005.

REQ-014 In TRACK, a required step beyond 0 or 2^CODE_WIDTH-1 SHALL saturate the code and enter ERROR with afc_status=0.

REQ-015 track_en falling while in TRACK SHALL complete any pending measurement, then go LOCKED and hold.

REQ-016 ERROR SHALL hold the code and set afc_error=1; it SHALL exit only on an afctrigger rising edge.

REQ-017 A full search SHALL issue at most CODE_WIDTH+1 measurements.

REQ-018 Each measurement SHALL carry (SETTLE_CYCLES + 1 + counter latency) cycles of latency.

REQ-019 target_count SHALL be sampled on each meas_valid, so changes take effect at the next decision.

Reset
REQ-020 While rst_n=0, outputs SHALL be:
- control_code_out = 2^(CODE_WIDTH-1);
- afc_status, afc_busy, afc_error, meas_start = 0;
- state = IDLE;
- all counters = 0.

REQ-021 Reset asserted mid-operation SHALL abort immediately with no pending measurement remembered.

REQ-022 After reset, an afctrigger already high SHALL NOT start a search; a new rising edge is required.

Verification
REQ-023 The bench SHALL use CODE_WIDTH=8, with a counter model returning 8*code after 20 cycles, and cover the following scenarios:
- target=1000: trial codes 128,64,96,112,120,124,126,125 -> early lock at code 125 after 8 measurements, afc_status=1.
- target=1024 -> lock after 1 measurement at code 128.
- Model never returns meas_valid -> afc_error=1 exactly TIMEOUT cycles after meas_start, afc_busy=0, code held.
- Lock at 125 with track_en=1, then model changes to 8*code-16 -> code 126 then 127, afc_status stays 1.
- target=5000, track_en=0 -> code 255 after search, VERIFY fails, afc_error=1; a new trigger clears it.
- Retrigger mid-search at code 96 -> code returns to 128 next cycle.
- rst_n pulsed low mid-search -> all outputs reach reset values asynchronously.
